tick_debouncer: RTL and testbench
=================================

Name: tick_debouncer

Overview:
- Debounces one noisy mechanical input, such as a button or switch. Stability is measured in ticks from the upstream parameterised timer, not in raw clk cycles.
- Sits directly downstream of the timer: the timer's one-cycle done strobe drives this block's tick input.
- Outputs a clean level plus single-cycle rise and fall pulses for downstream control logic.

Parameters:
- STABLE_TICKS, 4: consecutive ticks the input must hold a new level before it is accepted. Legal range >= 1; elaboration error if 0.
- CNT_BITS, $clog2(STABLE_TICKS+1): tick counter width. Derived; callers do not override it.

Ports:
- clk  input  1  system clock; all logic is on its rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- tick  input  1  stability-time strobe from the upstream timer. Every clk cycle it is high counts as one tick.
- noisy_in  input  1  raw input to be debounced.
- debounced  output  1  clean level, registered.
- rise  output  1  one-cycle pulse, high in the cycle debounced goes 0->1.
- fall  output  1  one-cycle pulse, high in the cycle debounced goes 1->0.
- busy  output  1  high while a candidate transition is being qualified (WAIT_HI or WAIT_LO).

Behaviour:
- Reset (async assert, sync release):
  - state=STABLE_LO, count=0.
  - debounced=0, rise=0, fall=0, busy=0.
  - Synchronizer flops (if present) reset to 0.
- Sampled input s_in: noisy_in, or its synchronized version when the optional feature is enabled.
- FSM states, 2-bit: STABLE_LO, WAIT_HI, STABLE_HI, WAIT_LO.
- STABLE_LO:
  - s_in=1 -> WAIT_HI, count=0.
  - Otherwise stay. tick is ignored.
- WAIT_HI:
  - s_in=0 -> STABLE_LO, count=0 (bounce abort). Abort has priority over a simultaneous tick.
  - Else if tick and count==STABLE_TICKS-1 -> STABLE_HI, count=0, debounced<=1, rise<=1 for one cycle.
  - Else if tick -> count+1.
  - Else hold.
- STABLE_HI / WAIT_LO: mirror of the above with levels inverted; acceptance asserts fall and clears debounced.
- Outputs are registered:
  - debounced, rise and fall update in the cycle after the accepting tick is sampled.
  - busy = (state==WAIT_HI or state==WAIT_LO), registered-state decode.
- Count range:
  - Never exceeds STABLE_TICKS-1; no wrap is possible.
  - count is cleared on every state change.
- STABLE_TICKS=1: the first tick seen in a WAIT state accepts the new level.
- tick held high for N consecutive cycles counts as N ticks.
- Ticks arriving in STABLE_* states have no effect.
- rise and fall are never high in the same cycle.
- Reset mid-qualification discards progress; the block returns to STABLE_LO with debounced=0 even if the input is held high.
- Minimum accept latency (no sync), from the first cycle s_in holds the new level: STABLE_TICKS tick strobes, plus 1 clk.

Optional Feature:
- Macro: TICK_DEBOUNCER_SYNC_EN.
- Defined: noisy_in passes through a two-flop synchronizer (reset value 0) before the FSM. All latencies grow by 2 clk. Required when noisy_in comes from a pin.
- Undefined: noisy_in feeds the FSM directly. The caller guarantees it is synchronous to clk.

Decomposition:
- Package tick_debouncer_pkg:
  - typedef for the state enum: STABLE_LO=2'b00, WAIT_HI=2'b01, STABLE_HI=2'b11, WAIT_LO=2'b10.
  - Constant for the synchronizer depth (2).
- Sub-module sync_2ff: a generic 1-bit two-flop synchronizer with async active-low reset. It is instantiated only under TICK_DEBOUNCER_SYNC_EN.

Test Plan:
Common setup: STABLE_TICKS=4; tick driven by a timer with FINAL_VALUE=9 and enable=1, so one strobe every 10 clk; sync disabled unless stated.
- Clean press: noisy_in 0->1 and held.
  - busy=1 from the next cycle.
  - debounced=1 and rise=1 for exactly one cycle, one clk after the 4th tick.
  - busy=0 afterwards.
- Bounce abort: noisy_in=1 for 2 ticks, then 0 for 1 clk, then 1 held.
  - No rise at the 4th tick after the original edge.
  - rise occurs one clk after the 4th tick counted from the re-assertion.
- Simultaneous abort and tick: noisy_in drops in the same cycle as the 4th tick.
  - State returns to STABLE_LO; debounced stays 0; no rise.
- Release: from STABLE_HI, noisy_in 1->0 and held.
  - fall=1 for one cycle and debounced=0, one clk after the 4th tick.
  - rise stays 0 throughout.
- Reset mid-wait: reset_n pulsed low after 3 ticks with noisy_in held 1.
  - All outputs 0 immediately.
  - After release, 4 fresh ticks are needed before rise.
- Sync build (TICK_DEBOUNCER_SYNC_EN defined): repeat the clean press.
  - rise appears exactly 2 clk later than in the non-sync build, given the same tick phase.
  - STABLE_TICKS=1 variant: rise one clk after the first tick.

Source files
------------

// File: rtl/tick_debouncer_pkg.sv
// Shared types and constants for the tick-based debouncer.
// State encoding keeps bit 0 as "waiting" on the low side and bit 1 as the accepted level.
package tick_debouncer_pkg;

    typedef enum logic [1:0] {
        STABLE_LO = 2'b00,
        WAIT_HI   = 2'b01,
        STABLE_HI = 2'b11,
        WAIT_LO   = 2'b10
    } state_t;

    localparam int SYNC_STAGES = 2;

endpackage

// File: rtl/sync_2ff.sv
// Generic 1-bit two-flop synchronizer with asynchronous active-low reset.
// Used only when TICK_DEBOUNCER_SYNC_EN is defined.
module sync_2ff
    import tick_debouncer_pkg::*;
(
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] chain;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            chain <= '0;
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], d};
        end
    end

    assign q = chain[SYNC_STAGES-1];

endmodule

// File: rtl/tick_debouncer.sv
// Debounces one noisy input, measuring stability in upstream timer ticks.
// Define TICK_DEBOUNCER_SYNC_EN to put a two-flop synchronizer in front of the FSM.
module tick_debouncer
    import tick_debouncer_pkg::*;
#(
    parameter int STABLE_TICKS = 4,
    parameter int CNT_BITS     = $clog2(STABLE_TICKS + 1)
) (
    input  logic clk,
    input  logic reset_n,
    input  logic tick,
    input  logic noisy_in,
    output logic debounced,
    output logic rise,
    output logic fall,
    output logic busy
);

    generate
        if (STABLE_TICKS < 1) begin : g_param_check
            $error("tick_debouncer: STABLE_TICKS must be at least 1");
        end
    endgenerate

    localparam logic [CNT_BITS-1:0] LAST_COUNT = CNT_BITS'(STABLE_TICKS - 1);

    logic                s_in;
    state_t              state;
    state_t              state_next;
    logic [CNT_BITS-1:0] count;
    logic [CNT_BITS-1:0] count_next;
    logic                debounced_next;
    logic                rise_next;
    logic                fall_next;

`ifdef TICK_DEBOUNCER_SYNC_EN
    sync_2ff u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (noisy_in),
        .q       (s_in)
    );
`else
    assign s_in = noisy_in;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= STABLE_LO;
            count     <= '0;
            debounced <= 1'b0;
            rise      <= 1'b0;
            fall      <= 1'b0;
        end else begin
            state     <= state_next;
            count     <= count_next;
            debounced <= debounced_next;
            rise      <= rise_next;
            fall      <= fall_next;
        end
    end

    // A level change in s_in aborts qualification before any tick is considered.
    always_comb begin
        state_next     = state;
        count_next     = count;
        debounced_next = debounced;
        rise_next      = 1'b0;
        fall_next      = 1'b0;
        case (state)
            STABLE_LO: begin
                if (s_in) begin
                    state_next = WAIT_HI;
                    count_next = '0;
                end
            end
            WAIT_HI: begin
                if (!s_in) begin
                    state_next = STABLE_LO;
                    count_next = '0;
                end else if (tick) begin
                    if (count == LAST_COUNT) begin
                        state_next     = STABLE_HI;
                        count_next     = '0;
                        debounced_next = 1'b1;
                        rise_next      = 1'b1;
                    end else begin
                        count_next = count + CNT_BITS'(1);
                    end
                end
            end
            STABLE_HI: begin
                if (!s_in) begin
                    state_next = WAIT_LO;
                    count_next = '0;
                end
            end
            WAIT_LO: begin
                if (s_in) begin
                    state_next = STABLE_HI;
                    count_next = '0;
                end else if (tick) begin
                    if (count == LAST_COUNT) begin
                        state_next     = STABLE_LO;
                        count_next     = '0;
                        debounced_next = 1'b0;
                        fall_next      = 1'b1;
                    end else begin
                        count_next = count + CNT_BITS'(1);
                    end
                end
            end
            default: begin
                state_next = STABLE_LO;
                count_next = '0;
            end
        endcase
    end

    assign busy = (state == WAIT_HI) || (state == WAIT_LO);

endmodule

// File: tb/tb_tick_debouncer.sv
// Self-checking bench for tick_debouncer: directed scenarios plus randomized input/tick
// sequences, compared each cycle against a level/tick-count reference model.
module tb_tick_debouncer;

    localparam int STABLE_TICKS = 4;
    localparam int TIMER_FINAL  = 9;
`ifdef TICK_DEBOUNCER_SYNC_EN
    localparam int SYNC_DELAY = 2;
`else
    localparam int SYNC_DELAY = 0;
`endif

    logic clk;
    logic reset_n;
    logic tick;
    logic noisy_in;
    logic debounced;
    logic rise;
    logic fall;
    logic busy;

    tick_debouncer #(
        .STABLE_TICKS (STABLE_TICKS)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .tick      (tick),
        .noisy_in  (noisy_in),
        .debounced (debounced),
        .rise      (rise),
        .fall      (fall),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: accepted level, whether a differing level is being timed, ticks seen.
    bit m_level;
    bit m_waiting;
    int m_ticks;
    bit m_rise;
    bit m_fall;
    bit s_pipe[$];

    int timer_cnt;
    bit rand_tick;
    int vectors;
    int miscompares;
    int rise_seen;
    int fall_seen;

    task automatic modelReset();
        m_level   = 1'b0;
        m_waiting = 1'b0;
        m_ticks   = 0;
        m_rise    = 1'b0;
        m_fall    = 1'b0;
        s_pipe.delete();
        repeat (SYNC_DELAY) s_pipe.push_back(1'b0);
    endtask

    // The first cycle a differing level is seen only arms the wait; later ticks are counted.
    task automatic modelStep(input bit in_val, input bit t);
        bit s;
        s_pipe.push_back(in_val);
        s = s_pipe.pop_front();
        m_rise = 1'b0;
        m_fall = 1'b0;
        if (s == m_level) begin
            m_waiting = 1'b0;
            m_ticks   = 0;
        end else if (!m_waiting) begin
            m_waiting = 1'b1;
            m_ticks   = 0;
        end else if (t) begin
            m_ticks++;
            if (m_ticks == STABLE_TICKS) begin
                m_level   = s;
                m_waiting = 1'b0;
                m_ticks   = 0;
                m_rise    = s;
                m_fall    = !s;
            end
        end
    endtask

    task automatic checkBit(input string name, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %b expected %b", name, obs, exp);
        end
    endtask

    task automatic checkCount(input string name, input int obs, input int exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0d expected %0d", name, obs, exp);
        end
    endtask

    task automatic checkOutput(input string tag);
        checkBit({tag, ".debounced"}, debounced, m_level);
        checkBit({tag, ".rise"}, rise, m_rise);
        checkBit({tag, ".fall"}, fall, m_fall);
        checkBit({tag, ".busy"}, busy, m_waiting);
        checkBit({tag, ".rise_and_fall"}, rise & fall, 1'b0);
        if (rise === 1'b1) rise_seen++;
        if (fall === 1'b1) fall_seen++;
    endtask

    // One clk cycle: drive at negedge, step the model at posedge, check at the next negedge.
    task automatic applyStimulus(input logic in_val, input string tag);
        noisy_in = in_val;
        tick     = rand_tick ? ($urandom_range(0, 3) == 0) : (timer_cnt == TIMER_FINAL);
        @(posedge clk);
        modelStep(in_val, tick);
        timer_cnt = (timer_cnt == TIMER_FINAL) ? 0 : timer_cnt + 1;
        @(negedge clk);
        checkOutput(tag);
    endtask

    task automatic holdTicks(input logic v, input int n, input string tag);
        int seen;
        seen = 0;
        while (seen < n) begin
            if (timer_cnt == TIMER_FINAL) seen++;
            applyStimulus(v, tag);
        end
    endtask

    task automatic untilPhase(input logic v, input int phase, input string tag);
        while (timer_cnt != phase) applyStimulus(v, tag);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vectors     = 0;
        miscompares = 0;
        rise_seen   = 0;
        fall_seen   = 0;
        timer_cnt   = 0;
        rand_tick   = 1'b0;
        reset_n     = 1'b0;
        noisy_in    = 1'b0;
        tick        = 1'b0;
        modelReset();

        repeat (3) @(negedge clk);
        checkBit("reset.debounced", debounced, 1'b0);
        checkBit("reset.rise", rise, 1'b0);
        checkBit("reset.fall", fall, 1'b0);
        checkBit("reset.busy", busy, 1'b0);
        reset_n = 1'b1;

        // Clean press
        untilPhase(1'b0, 0, "idle");
        rise_seen = 0;
        applyStimulus(1'b1, "press");
        holdTicks(1'b1, STABLE_TICKS, "press");
        repeat (15) applyStimulus(1'b1, "press");
        checkCount("press.rise_count", rise_seen, 1);
        checkBit("press.level", debounced, 1'b1);

        // Clean release
        untilPhase(1'b1, 0, "high");
        rise_seen = 0;
        fall_seen = 0;
        applyStimulus(1'b0, "release");
        holdTicks(1'b0, STABLE_TICKS, "release");
        repeat (15) applyStimulus(1'b0, "release");
        checkCount("release.fall_count", fall_seen, 1);
        checkCount("release.rise_count", rise_seen, 0);
        checkBit("release.level", debounced, 1'b0);

        // Bounce abort: the dropout restarts qualification
        untilPhase(1'b0, 0, "idle");
        rise_seen = 0;
        applyStimulus(1'b1, "bounce");
        holdTicks(1'b1, 2, "bounce");
        applyStimulus(1'b0, "bounce");
        holdTicks(1'b1, 2, "bounce");
        checkCount("bounce.early_rise", rise_seen, 0);
        holdTicks(1'b1, STABLE_TICKS - 2, "bounce");
        repeat (15) applyStimulus(1'b1, "bounce");
        checkCount("bounce.rise_count", rise_seen, 1);
        holdTicks(1'b0, STABLE_TICKS + 1, "bounce_release");
        repeat (15) applyStimulus(1'b0, "bounce_release");

        // Abort lands in the FSM on the same cycle as the accepting tick
        untilPhase(1'b0, 0, "idle");
        rise_seen = 0;
        applyStimulus(1'b1, "collide");
        holdTicks(1'b1, STABLE_TICKS - 1, "collide");
        untilPhase(1'b1, TIMER_FINAL - SYNC_DELAY, "collide");
        applyStimulus(1'b0, "collide");
        repeat (40) applyStimulus(1'b0, "collide");
        checkCount("collide.rise_count", rise_seen, 0);
        checkBit("collide.level", debounced, 1'b0);

        // Reset mid-qualification
        untilPhase(1'b0, 0, "idle");
        applyStimulus(1'b1, "midreset");
        holdTicks(1'b1, STABLE_TICKS - 1, "midreset");
        repeat (2) applyStimulus(1'b1, "midreset");
        #2 reset_n = 1'b0;
        #1;
        checkBit("midreset.debounced", debounced, 1'b0);
        checkBit("midreset.rise", rise, 1'b0);
        checkBit("midreset.fall", fall, 1'b0);
        checkBit("midreset.busy", busy, 1'b0);
        modelReset();
        @(posedge clk);
        @(negedge clk);
        reset_n   = 1'b1;
        rise_seen = 0;
        holdTicks(1'b1, STABLE_TICKS - 1, "after_reset");
        repeat (5) applyStimulus(1'b1, "after_reset");
        checkCount("after_reset.early_rise", rise_seen, 0);
        holdTicks(1'b1, 2, "after_reset");
        repeat (15) applyStimulus(1'b1, "after_reset");
        checkCount("after_reset.rise_count", rise_seen, 1);

        // Randomized input runs with either timer ticks or random (possibly back-to-back) ticks
        for (int seg = 0; seg < 60; seg++) begin
            logic v;
            int   len;
            v         = 1'($urandom_range(0, 1));
            len       = $urandom_range(1, 14);
            rand_tick = 1'($urandom_range(0, 1));
            repeat (len) applyStimulus(v, "random");
        end
        rand_tick = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
